// File: rtl/mem_arb_ctrl.sv
// mem_arb_ctrl
//   Round-robin arbiter and access sequencer for a two-requester shared SRAM
//   bus. Each grant runs one read or one write through the sequence
//   SETUP (1 cycle) -> STROBE (WAIT_CYCLES cycles) -> RECOVER (1 cycle).
//   All outputs are registered. The only combinational path to a pin is the
//   tristate buffer on mem_data, whose enable and value are both registers.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   req0/wr0/addr0/wdata0      requester 0 level request, direction (1=write),
//                              address, write data
//   ack0, rdata0               requester 0 one-cycle completion pulse; read data
//                              is valid with ack0 and held until the next read
//   req1 ... rdata1            same for requester 1
//   mem_addr, mem_data         memory address and bidirectional data bus
//   mem_cs, mem_we, mem_oe     active-high chip select, write and output enable
//   busy                       high whenever the sequencer is not idle
//   grant                      index of the current or most recent grant
module mem_arb_ctrl #(
    parameter int ADDR_WIDTH  = 13,
    parameter int DATA_WIDTH  = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic                  wr0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic                  ack0,
    output logic [DATA_WIDTH-1:0] rdata0,
    input  logic                  req1,
    input  logic                  wr1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    inout  wire  [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe,
    output logic                  busy,
    output logic                  grant
);

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, RECOVER} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  grant_q, grant_d;   // doubles as last_grant
    logic                  cs_q, cs_d;
    logic                  we_q, we_d;
    logic                  oe_q, oe_d;
    logic                  drv_q, drv_d;       // controller owns mem_data
    logic                  ack0_q, ack0_d;
    logic                  ack1_q, ack1_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
    logic                  busy_q, busy_d;
    logic                  sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            grant_q  <= 1'b1;   // requester 0 wins the first tie
            cs_q     <= 1'b0;
            we_q     <= 1'b0;
            oe_q     <= 1'b0;
            drv_q    <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            grant_q  <= grant_d;
            cs_q     <= cs_d;
            we_q     <= we_d;
            oe_q     <= oe_d;
            drv_q    <= drv_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            busy_q   <= busy_d;
        end
    end

    // Output registers are loaded with the values belonging to the state being
    // entered, so every pin lines up with its state without a decode stage.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        grant_d  = grant_q;
        cs_d     = 1'b0;
        we_d     = 1'b0;
        oe_d     = 1'b0;
        drv_d    = 1'b0;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;

        // On a tie the requester that did not win last time goes next.
        sel = 1'b0;
        if (req0 && req1) begin
            sel = ~grant_q;
        end else if (req1) begin
            sel = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    grant_d = sel;
                    wr_d    = sel ? wr1    : wr0;
                    addr_d  = sel ? addr1  : addr0;
                    wdata_d = sel ? wdata1 : wdata0;
                    state_d = SETUP;
                    cs_d    = 1'b1;
                    drv_d   = wr_d;
                end
            end
            SETUP: begin
                state_d = STROBE;
                cnt_d   = '0;
                cs_d    = 1'b1;
                we_d    = wr_q;
                oe_d    = ~wr_q;
                drv_d   = wr_q;
            end
            STROBE: begin
                if (cnt_q == CNT_LAST) begin
                    // Last strobe cycle: the read data is taken on this edge
                    // while mem_oe is still asserted.
                    state_d = RECOVER;
                    ack0_d  = ~grant_q;
                    ack1_d  = grant_q;
                    if (!wr_q) begin
                        if (grant_q) begin
                            rdata1_d = mem_data;
                        end else begin
                            rdata0_d = mem_data;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    cs_d  = 1'b1;
                    we_d  = wr_q;
                    oe_d  = ~wr_q;
                    drv_d = wr_q;
                end
            end
            RECOVER: begin
                // mem_cs stays low here and in the following IDLE cycle,
                // which gives the bus its turnaround gap.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign mem_data = drv_q ? wdata_q : {DATA_WIDTH{1'bz}};
    assign mem_addr = addr_q;
    assign mem_cs   = cs_q;
    assign mem_we   = we_q;
    assign mem_oe   = oe_q;
    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign rdata0   = rdata0_q;
    assign rdata1   = rdata1_q;
    assign busy     = busy_q;
    assign grant    = grant_q;

endmodule

// File: tb/tb_mem_arb_ctrl.sv
// Bench for mem_arb_ctrl: a default build (WAIT_CYCLES=2) with a word-array
// memory model on its bus, plus a WAIT_CYCLES=4 build whose memory only
// returns data in the final strobe cycle.
module tb_mem_arb_ctrl;

    localparam int AW = 13;
    localparam int DW = 16;
    localparam int W  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // ---------------- default build ----------------
    logic [1:0]         req_r = '0;
    logic [1:0]         wr_r  = '0;
    logic [1:0][AW-1:0] addr_r  = '0;
    logic [1:0][DW-1:0] wdata_r = '0;
    logic               ack0_w, ack1_w;
    logic [DW-1:0]      rdata0_w, rdata1_w;
    logic [AW-1:0]      mem_addr;
    wire  [DW-1:0]      mem_data;
    logic               mem_cs, mem_we, mem_oe, busy, grant;

    mem_arb_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(W)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req_r[0]), .wr0(wr_r[0]), .addr0(addr_r[0]), .wdata0(wdata_r[0]),
        .ack0(ack0_w), .rdata0(rdata0_w),
        .req1(req_r[1]), .wr1(wr_r[1]), .addr1(addr_r[1]), .wdata1(wdata_r[1]),
        .ack1(ack1_w), .rdata1(rdata1_w),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_cs(mem_cs),
        .mem_we(mem_we), .mem_oe(mem_oe), .busy(busy), .grant(grant)
    );

    // Memory model. probe_en forces the bus to zero so that any value other
    // than zero shows the controller is also driving it.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          probe_en = 1'b0;
    logic          tb_en;
    logic [DW-1:0] tb_val;
    assign tb_en    = probe_en | (mem_oe & mem_cs);
    assign tb_val   = probe_en ? '0 : mem[mem_addr];
    assign mem_data = tb_en ? tb_val : {DW{1'bz}};
    always @(posedge clk) if (rst_n && mem_cs && mem_we) mem[mem_addr] <= mem_data;

    // Bus invariants and ack totals, sampled on the falling edge.
    int   v_cnt = 0;
    int   ack_tot0 = 0, ack_tot1 = 0;
    logic pa0 = 1'b0, pa1 = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            v_cnt <= v_cnt + int'(mem_we && mem_oe) + int'(ack0_w && ack1_w)
                   + int'((ack0_w || ack1_w) && mem_cs) + int'((mem_we || mem_oe) && !mem_cs)
                   + int'(ack0_w && pa0) + int'(ack1_w && pa1);
            ack_tot0 <= ack_tot0 + int'(ack0_w);
            ack_tot1 <= ack_tot1 + int'(ack1_w);
            pa0 <= ack0_w;
            pa1 <= ack1_w;
        end else begin
            pa0 <= 1'b0;
            pa1 <= 1'b0;
        end
    end

    // ---------------- WAIT_CYCLES=4 build ----------------
    logic          req4 = 1'b0, wr4 = 1'b0, zero4 = 1'b0;
    logic [AW-1:0] addr4 = '0, zaddr4 = '0;
    logic [DW-1:0] wdata4 = '0, zdata4 = '0;
    logic          ack4_0, ack4_1, mem_cs4, mem_we4, mem_oe4, busy4, grant4;
    logic [DW-1:0] rdata4_0, rdata4_1;
    logic [AW-1:0] mem_addr4;
    wire  [DW-1:0] mem_data4;
    int            oe4_cnt;

    mem_arb_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .req0(req4), .wr0(wr4), .addr0(addr4), .wdata0(wdata4),
        .ack0(ack4_0), .rdata0(rdata4_0),
        .req1(zero4), .wr1(zero4), .addr1(zaddr4), .wdata1(zdata4),
        .ack1(ack4_1), .rdata1(rdata4_1),
        .mem_addr(mem_addr4), .mem_data(mem_data4), .mem_cs(mem_cs4),
        .mem_we(mem_we4), .mem_oe(mem_oe4), .busy(busy4), .grant(grant4)
    );

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) oe4_cnt <= 0;
        else        oe4_cnt <= mem_oe4 ? oe4_cnt + 1 : 0;
    end
    assign mem_data4 = (mem_oe4 && mem_cs4 && oe4_cnt == 3) ? 16'hBEEF : {DW{1'bz}};

    // ---------------- helpers ----------------
    function automatic logic ack_of(input int p);
        return (p == 1) ? ack1_w : ack0_w;
    endfunction

    function automatic logic [DW-1:0] rdata_of(input int p);
        return (p == 1) ? rdata1_w : rdata0_w;
    endfunction

    // One requester transaction: raise req, hold until ack, then drop req.
    task automatic access(input int p, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, output int lat, output logic [DW-1:0] rd,
                          output int n_we, output int n_oe, output int n_bad);
        @(negedge clk);
        req_r[p] = 1'b1; wr_r[p] = w; addr_r[p] = a; wdata_r[p] = d;
        lat = 0; n_we = 0; n_oe = 0; n_bad = 0; rd = '0;
        forever begin
            @(negedge clk);
            lat++;
            if (mem_we) n_we++;
            if (mem_oe) n_oe++;
            if (mem_cs && (grant == p[0]) && (mem_addr != a)) n_bad++;
            if (ack_of(p)) break;
            if (lat > 60) begin
                checks++; fails++;
                $display("FAIL access_timeout port=%0d: no ack after %0d cycles, required within 60", p, lat);
                break;
            end
        end
        rd = rdata_of(p);
        req_r[p] = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        probe_en = 1'b1;
        #1;
        checks++; if ({mem_cs, mem_we, mem_oe} !== 3'b000) begin fails++; $display("FAIL reset_strobes got %b required 000", {mem_cs, mem_we, mem_oe}); end
        checks++; if (mem_addr !== '0) begin fails++; $display("FAIL reset_addr got %h required 0000", mem_addr); end
        checks++; if ({ack0_w, ack1_w, busy} !== 3'b000) begin fails++; $display("FAIL reset_ack_busy got %b required 000", {ack0_w, ack1_w, busy}); end
        checks++; if ((rdata0_w !== '0) || (rdata1_w !== '0)) begin fails++; $display("FAIL reset_rdata got %h/%h required 0000/0000", rdata0_w, rdata1_w); end
        checks++; if (grant !== 1'b1) begin fails++; $display("FAIL reset_grant got %b required 1", grant); end
        checks++; if (mem_data !== '0) begin fails++; $display("FAIL reset_bus_driven got %h required 0000 (bus released)", mem_data); end
        probe_en = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_single_rw();
        int lat, nwe, noe, nbad;
        logic [DW-1:0] rd;
        access(0, 1'b1, 13'h0005, 16'hA5C3, lat, rd, nwe, noe, nbad);
        checks++; if (lat != W + 2) begin fails++; $display("FAIL wr0_latency got %0d required %0d", lat, W + 2); end
        checks++; if ((noe != 0) || (nwe != W) || (nbad != 0)) begin fails++; $display("FAIL wr0_strobes got we=%0d oe=%0d badaddr=%0d required we=%0d oe=0 badaddr=0", nwe, noe, nbad, W); end
        access(0, 1'b0, 13'h0005, 16'h0000, lat, rd, nwe, noe, nbad);
        checks++; if (lat != W + 2) begin fails++; $display("FAIL rd0_latency got %0d required %0d", lat, W + 2); end
        checks++; if (rd !== 16'hA5C3) begin fails++; $display("FAIL rd0_data got %h required a5c3", rd); end
        checks++; if ((nwe != 0) || (noe != W) || (nbad != 0)) begin fails++; $display("FAIL rd0_strobes got we=%0d oe=%0d badaddr=%0d required we=0 oe=%0d badaddr=0", nwe, noe, nbad, W); end
        access(0, 1'b1, 13'h0006, 16'h1111, lat, rd, nwe, noe, nbad);
        checks++; if (rd !== 16'hA5C3) begin fails++; $display("FAIL rd0_hold_after_write got %h required a5c3", rd); end
    endtask

    task automatic test_bank_cross();
        int lat, nwe, noe, nbad;
        logic [DW-1:0] rd;
        access(1, 1'b1, 13'h1FFF, 16'h1234, lat, rd, nwe, noe, nbad);
        access(1, 1'b1, 13'h0FFF, 16'h5678, lat, rd, nwe, noe, nbad);
        access(1, 1'b0, 13'h1FFF, 16'h0000, lat, rd, nwe, noe, nbad);
        checks++; if (rd !== 16'h1234) begin fails++; $display("FAIL bank_hi_read got %h required 1234", rd); end
        checks++; if ((lat != W + 2) || (nbad != 0)) begin fails++; $display("FAIL bank_hi_timing got lat=%0d badaddr=%0d required lat=%0d badaddr=0", lat, nbad, W + 2); end
        access(1, 1'b0, 13'h0FFF, 16'h0000, lat, rd, nwe, noe, nbad);
        checks++; if (rd !== 16'h5678) begin fails++; $display("FAIL bank_lo_read got %h required 5678", rd); end
    endtask

    task automatic test_arb_order();
        int   got[$];
        int   gnt[$];
        int   when[$];
        int   cyc;
        int   expw;
        logic last;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        req_r = 2'b11; wr_r = 2'b00; addr_r[0] = 13'h0010; addr_r[1] = 13'h0011;
        cyc = 0;
        while ((got.size() < 4) && (cyc < 60)) begin
            @(negedge clk);
            cyc++;
            if (ack0_w || ack1_w) begin
                got.push_back(ack1_w ? 1 : 0);
                gnt.push_back(int'(grant));
                when.push_back(cyc);
            end
        end
        req_r = 2'b00;
        checks++; if (got.size() != 4) begin fails++; $display("FAIL arb_ack_count got %0d required 4", got.size()); end
        // Both requesters always pending: each grant goes to the one that
        // did not win last, starting as if requester 1 had just won.
        last = 1'b1;
        foreach (got[k]) begin
            expw = last ? 0 : 1;
            checks++; if ((got[k] != expw) || (gnt[k] != expw)) begin fails++; $display("FAIL arb_order[%0d] got ack=%0d grant=%0d required %0d", k, got[k], gnt[k], expw); end
            checks++;
            if (k == 0) begin
                if (when[k] != W + 2) begin fails++; $display("FAIL arb_first_latency got %0d required %0d", when[k], W + 2); end
            end else if (when[k] - when[k-1] != W + 3) begin
                fails++; $display("FAIL arb_spacing[%0d] got %0d required %0d", k, when[k] - when[k-1], W + 3);
            end
            last = expw[0];
        end
    endtask

    task automatic test_reset_mid_write();
        int lat, nwe, noe, nbad, n, acks;
        logic [DW-1:0] rd;
        @(negedge clk);
        req_r[0] = 1'b1; wr_r[0] = 1'b1; addr_r[0] = 13'h0AAA; wdata_r[0] = 16'h5A5A;
        n = 0;
        while (!mem_we && n < 10) begin @(negedge clk); n++; end
        req_r[0] = 1'b0;
        checks++; if (!(mem_we && busy && mem_cs)) begin fails++; $display("FAIL midwr_strobe got we=%b busy=%b cs=%b required 1/1/1", mem_we, busy, mem_cs); end
        acks = ack_tot0 + ack_tot1;
        #2 rst_n = 1'b0;
        probe_en = 1'b1;
        #1;
        checks++; if ({mem_cs, mem_we, mem_oe, busy} !== 4'b0000) begin fails++; $display("FAIL midwr_async_drop got cs/we/oe/busy=%b required 0000", {mem_cs, mem_we, mem_oe, busy}); end
        checks++; if (mem_data !== '0) begin fails++; $display("FAIL midwr_bus_released got %h required 0000", mem_data); end
        checks++; if ((grant !== 1'b1) || (rdata0_w !== '0) || (mem_addr !== '0)) begin fails++; $display("FAIL midwr_reset_regs got grant=%b rdata0=%h addr=%h required 1/0000/0000", grant, rdata0_w, mem_addr); end
        probe_en = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (ack_tot0 + ack_tot1 != acks) begin fails++; $display("FAIL midwr_no_ack got %0d acks required %0d", ack_tot0 + ack_tot1, acks); end
        access(1, 1'b1, 13'h0100, 16'h7777, lat, rd, nwe, noe, nbad);
        checks++; if ((lat != W + 2) || (grant !== 1'b1)) begin fails++; $display("FAIL midwr_req1_after got lat=%0d grant=%b required %0d/1", lat, grant, W + 2); end
        access(1, 1'b0, 13'h0100, 16'h0000, lat, rd, nwe, noe, nbad);
        checks++; if (rd !== 16'h7777) begin fails++; $display("FAIL midwr_req1_read got %h required 7777", rd); end
    endtask

    task automatic test_wait4();
        int lat, noe, nwe, nbad;
        @(negedge clk);
        req4 = 1'b1; wr4 = 1'b0; addr4 = 13'h0123;
        lat = 0; noe = 0; nwe = 0; nbad = 0;
        forever begin
            @(negedge clk);
            lat++;
            if (mem_oe4) noe++;
            if (mem_we4 || ack4_1) nwe++;
            if (mem_cs4 && mem_addr4 != 13'h0123) nbad++;
            if (ack4_0 || lat > 40) break;
        end
        req4 = 1'b0;
        checks++; if (lat != 6) begin fails++; $display("FAIL w4_latency got %0d required 6", lat); end
        checks++; if (noe != 4) begin fails++; $display("FAIL w4_oe_cycles got %0d required 4", noe); end
        checks++; if (rdata4_0 !== 16'hBEEF) begin fails++; $display("FAIL w4_rdata got %h required beef", rdata4_0); end
        checks++; if ((nwe != 0) || (nbad != 0) || (grant4 !== 1'b0) || (rdata4_1 !== '0)) begin fails++; $display("FAIL w4_side got we/ack1=%0d badaddr=%0d grant=%b rdata1=%h required 0/0/0/0000", nwe, nbad, grant4, rdata4_1); end
        @(negedge clk); @(negedge clk);
        checks++; if (busy4 !== 1'b0) begin fails++; $display("FAIL w4_idle_busy got %b required 0", busy4); end
    endtask

    // Each port works in its own address slice (bit 0 = port), so the
    // expected read value depends only on that port's own earlier writes.
    task automatic worker(input int p, input int n);
        logic [DW-1:0] expm [int];
        int            wq[$];
        int            lat, nwe, noe, nbad, a;
        logic [DW-1:0] rd, d;
        logic          w;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            w = (wq.size() == 0) || ($urandom_range(0, 1) == 1);
            if (w) a = int'(($urandom_range(0, 1) << 12) | ($urandom_range(0, 31) << 1) | p);
            else   a = wq[$urandom_range(0, wq.size() - 1)];
            d = DW'($urandom);
            access(p, w, AW'(a), d, lat, rd, nwe, noe, nbad);
            if (w) begin
                if (!expm.exists(a)) wq.push_back(a);
                expm[a] = d;
            end else begin
                checks++; if (rd !== expm[a]) begin fails++; $display("FAIL rand_read port=%0d addr=%h got %h required %h", p, a, rd, expm[a]); end
            end
            checks++; if (nbad != 0) begin fails++; $display("FAIL rand_addr port=%0d got %0d wrong-address cycles required 0", p, nbad); end
        end
    endtask

    task automatic test_random();
        int b0, b1;
        b0 = ack_tot0; b1 = ack_tot1;
        fork
            worker(0, 100);
            worker(1, 100);
        join
        repeat (3) @(negedge clk);
        checks++; if (ack_tot0 - b0 != 100) begin fails++; $display("FAIL rand_acks0 got %0d required 100", ack_tot0 - b0); end
        checks++; if (ack_tot1 - b1 != 100) begin fails++; $display("FAIL rand_acks1 got %0d required 100", ack_tot1 - b1); end
    endtask

    task automatic test_invariants();
        checks++; if (v_cnt != 0) begin fails++; $display("FAIL bus_invariants got %0d violations required 0", v_cnt); end
    endtask

    initial begin
        test_reset();
        test_single_rw();
        test_bank_cross();
        test_arb_order();
        test_reset_mid_write();
        test_wait4();
        test_random();
        test_invariants();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within 400000 time units");
        $fatal(1, "watchdog");
    end

endmodule
